// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner and other timer blocks.
package key_conditioner_pkg;

    // Edge/repeat FSM state encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DELAY  = 2'b01,
        REPEAT = 2'b10
    } kc_state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : int'($clog2(max_val + 1));
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter producing the debounced level.
module key_debounce
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic held,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CW = cnt_width(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          key_s;
    logic [CW-1:0] cnt;
    logic          accept_c;

    // The differing level has persisted long enough to be taken on this edge.
    assign accept_c = (key_s != held) && (cnt == CNT_LAST);
    assign rise_c   = accept_c && key_s;
    assign fall_c   = accept_c && !key_s;

    // Synchronise the inverted (active-high) key into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            key_s <= 1'b0;
        end else begin
            sync1 <= ~key_n;
            key_s <= sync1;
        end
    end

    // Count consecutive differing cycles; any bounce back discards the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            held <= 1'b0;
        end else if (key_s == held) begin
            cnt <= '0;
        end else if (accept_c) begin
            cnt  <= '0;
            held <= key_s;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Per-key conditioner: debounced level, press/release pulses and auto-repeat.
// The release pulse port is named "released" because "release" is reserved.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 16,
    parameter bit          AUTO_REPEAT   = 1'b1,
    parameter int unsigned REPEAT_DELAY  = 64,
    parameter int unsigned REPEAT_PERIOD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic held,
    output logic press,
    output logic released,
    output logic repeating
);

    localparam int unsigned TMR_MAX =
        ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
    localparam int unsigned TW = cnt_width(TMR_MAX);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    kc_state_e     state;
    logic [TW-1:0] tmr;
    logic          rise_c;
    logic          fall_c;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n),
        .held  (held),
        .rise_c(rise_c),
        .fall_c(fall_c)
    );

    // Edge/repeat FSM; a release always wins over a repeat tick due the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            press     <= 1'b0;
            released  <= 1'b0;
            repeating <= 1'b0;
        end else begin
            press    <= 1'b0;
            released <= 1'b0;
            if (fall_c) begin
                released  <= 1'b1;
                tmr       <= '0;
                state     <= IDLE;
                repeating <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise_c) begin
                            press <= 1'b1;
                            tmr   <= '0;
                            if (AUTO_REPEAT) state <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (tmr == DELAY_LAST) begin
                            press     <= 1'b1;
                            tmr       <= '0;
                            state     <= REPEAT;
                            repeating <= 1'b1;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (tmr == PERIOD_LAST) begin
                            press <= 1'b1;
                            tmr   <= '0;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        tmr       <= '0;
                        repeating <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: two instances (repeat off / on) share one key.
module tb_key_conditioner;

    localparam int unsigned D  = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned RP = 3;

    logic clk;
    logic rst_n;
    logic key_n;
    logic held_n, press_n, rel_n, rep_n;
    logic held_r, press_r, rel_r, rep_r;

    int n_cmp;
    int n_bad;
    int press_cnt_n;
    int rel_cnt_r;

    logic [7:0] exp_q[$];

    key_conditioner #(
        .DEB_CYCLES(D), .AUTO_REPEAT(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_norep (
        .clk(clk), .rst_n(rst_n), .key_n(key_n),
        .held(held_n), .press(press_n), .released(rel_n), .repeating(rep_n)
    );

    key_conditioner #(
        .DEB_CYCLES(D), .AUTO_REPEAT(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_rep (
        .clk(clk), .rst_n(rst_n), .key_n(key_n),
        .held(held_r), .press(press_r), .released(rel_r), .repeating(rep_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Reference model: sync, stability run length, and press age since acceptance.
    logic m_s1, m_s2, m_held, m_rpt;
    int   m_run, m_age;
    always @(posedge clk) begin
        logic rose, fell, p_r, r_r;
        rose = 1'b0; fell = 1'b0; p_r = 1'b0; r_r = 1'b0;
        if (!rst_n) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_held = 1'b0; m_rpt = 1'b0;
            m_run = 0; m_age = 0;
        end else begin
            if (m_s2 != m_held) begin
                m_run++;
                if (m_run == int'(D)) begin
                    m_held = ~m_held;
                    m_run  = 0;
                    rose   = m_held;
                    fell   = ~m_held;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = ~key_n;
            if (fell) begin
                r_r = 1'b1; m_age = 0; m_rpt = 1'b0;
            end else if (rose) begin
                p_r = 1'b1; m_age = 0;
            end else if (m_held) begin
                m_age++;
                if (m_age == int'(RD)) begin
                    p_r = 1'b1; m_rpt = 1'b1;
                end else if (m_age > int'(RD) && ((m_age - int'(RD)) % int'(RP)) == 0) begin
                    p_r = 1'b1;
                end
            end
        end
        exp_q.push_back({m_held, rose, fell, 1'b0, m_held, p_r, r_r, m_rpt});
    end

    // Scoreboard: compare both instances against the model every cycle.
    always @(negedge clk) begin
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("norep_outs", {28'd0, held_n, press_n, rel_n, rep_n}, {28'd0, e[7:4]});
            check("rep_outs",   {28'd0, held_r, press_r, rel_r, rep_r}, {28'd0, e[3:0]});
        end
        if (press_n) press_cnt_n++;
        if (rel_r)   rel_cnt_r++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; press_cnt_n = 0; rel_cnt_r = 0;
        rst_n = 1'b0;
        key_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check("reset_outs", {28'd0, held_r, press_r, rel_r, rep_r}, 32'd0);

        // Clean press, then auto-repeat schedule on the repeating instance.
        key_n = 1'b0;
        tick(5);
        check("press_early", 32'(press_n), 32'd0);
        tick(1);
        check("press_lat",   32'(press_n), 32'd1);
        check("held_lat",    32'(held_n),  32'd1);
        check("press_lat_r", 32'(press_r), 32'd1);
        tick(1);
        check("press_one_cycle", 32'(press_n), 32'd0);
        press_cnt_n = 0;
        tick(6);
        check("rpt_early", 32'(press_r), 32'd0);
        tick(1);
        check("rpt_first", 32'(press_r), 32'd1);
        check("rpt_flag",  32'(rep_r),   32'd1);
        tick(3);
        check("rpt_p11", 32'(press_r), 32'd1);
        tick(3);
        check("rpt_p14", 32'(press_r), 32'd1);
        tick(3);
        check("rpt_p17", 32'(press_r), 32'd1);
        tick(3);
        check("norep_quiet", 32'(press_cnt_n), 32'd0);

        // Release after a long hold.
        key_n = 1'b1;
        tick(5);
        check("rel_early", 32'(rel_n), 32'd0);
        tick(1);
        check("rel_lat",      32'(rel_n),   32'd1);
        check("rel_held",     32'(held_n),  32'd0);
        check("rel_r",        32'(rel_r),   32'd1);
        check("rel_no_press", 32'(press_r), 32'd0);
        check("rel_rpt_off",  32'(rep_r),   32'd0);
        tick(10);

        // Bounce: low 3, high 1, then low steady.
        press_cnt_n = 0;
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(1);
        key_n = 1'b0;
        tick(5);
        check("bounce_quiet", 32'(press_cnt_n), 32'd0);
        tick(1);
        check("bounce_press", 32'(press_n), 32'd1);
        key_n = 1'b1;
        tick(15);

        // Release landing on the +14 repeat tick.
        key_n = 1'b0;
        tick(6);
        check("col_press", 32'(press_r), 32'd1);
        tick(8);
        check("col_first_rpt", 32'(press_r), 32'd1);
        key_n = 1'b1;
        tick(6);
        check("col_rel",   32'(rel_r),   32'd1);
        check("col_press0", 32'(press_r), 32'd0);
        check("col_rpt0",  32'(rep_r),   32'd0);
        tick(10);

        // Reset while repeating, key kept pressed through deassertion.
        key_n = 1'b0;
        tick(6);
        tick(9);
        check("pre_rst_rpt", 32'(rep_r), 32'd1);
        rel_cnt_r = 0;
        rst_n = 1'b0;
        #1;
        check("rst_outs_r", {28'd0, held_r, press_r, rel_r, rep_r}, 32'd0);
        check("rst_held_n", 32'(held_n), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check("rst_press_early", 32'(press_r), 32'd0);
        tick(1);
        check("rst_press_r", 32'(press_r), 32'd1);
        check("rst_press_n", 32'(press_n), 32'd1);
        check("rst_no_rel",  32'(rel_cnt_r), 32'd0);
        key_n = 1'b1;
        tick(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
